// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between the instruction-fetch (IF) and load/store (LS) ports.
// LS has fixed priority; IF is forced through after MAX_WAIT consecutive denied cycles.
module mem_port_arbiter #(
  parameter int A_WIDTH  = 8,
  parameter int D_WIDTH  = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [A_WIDTH-1:0]   if_addr,
  output logic                 if_gnt,
  output logic                 if_valid,
  output logic [D_WIDTH-1:0]   if_rdata,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [D_WIDTH/8-1:0] ls_wstrb,
  input  logic [A_WIDTH-1:0]   ls_addr,
  input  logic [D_WIDTH-1:0]   ls_wdata,
  output logic                 ls_gnt,
  output logic                 ls_valid,
  output logic [D_WIDTH-1:0]   ls_rdata,
  output logic                 stall_if,
  output logic                 stall_ls,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [D_WIDTH/8-1:0] mem_wstrb,
  output logic [A_WIDTH-1:0]   mem_addr,
  output logic [D_WIDTH-1:0]   mem_wdata,
  input  logic [D_WIDTH-1:0]   mem_rdata
);

  localparam int         S_WIDTH    = D_WIDTH / 8;
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_IF    = 2'd1,
    RESP_LS_RD = 2'd2,
    RESP_LS_WR = 2'd3
  } resp_e;

  resp_e      resp_src_r;
  resp_e      resp_src_next_s;
  logic [3:0] wait_cnt_r;
  logic [3:0] wait_cnt_next_s;
  logic       force_if_s;
  logic       if_win_s;
  logic       ls_win_s;

  // Winner selection; no grant is issued while reset is asserted
  always_comb begin
    force_if_s = (wait_cnt_r == MAX_WAIT_C);
    if_win_s   = 1'b0;
    ls_win_s   = 1'b0;
    if (rst) begin
      if_win_s = 1'b0;
      ls_win_s = 1'b0;
    end else if (ls_req && !(force_if_s && if_req)) begin
      ls_win_s = 1'b1;
    end else if (if_req) begin
      if_win_s = 1'b1;
    end else begin
      ls_win_s = 1'b0;
    end
  end

  // Handshake outputs and memory-side mux driven by the winner
  always_comb begin
    if_gnt    = if_win_s;
    ls_gnt    = ls_win_s;
    stall_if  = if_req && !if_win_s && !rst;
    stall_ls  = ls_req && !ls_win_s && !rst;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = {S_WIDTH{1'b0}};
    mem_addr  = {A_WIDTH{1'b0}};
    mem_wdata = {D_WIDTH{1'b0}};
    if (ls_win_s) begin
      mem_cs    = 1'b1;
      mem_we    = ls_we;
      mem_wstrb = ls_we ? ls_wstrb : {S_WIDTH{1'b0}};
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_win_s) begin
      mem_cs   = 1'b1;
      mem_addr = if_addr;
    end else begin
      mem_cs = 1'b0;
    end
  end

  // Next response source and starvation count (saturates at MAX_WAIT)
  always_comb begin
    resp_src_next_s = RESP_NONE;
    wait_cnt_next_s = 4'd0;
    if (ls_win_s) begin
      resp_src_next_s = ls_we ? RESP_LS_WR : RESP_LS_RD;
    end else if (if_win_s) begin
      resp_src_next_s = RESP_IF;
    end else begin
      resp_src_next_s = RESP_NONE;
    end
    if (if_req && !if_win_s) begin
      wait_cnt_next_s = (wait_cnt_r == MAX_WAIT_C) ? wait_cnt_r : wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_next_s = 4'd0;
    end
  end

  // State registers; reset drops any in-flight response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_src_r <= RESP_NONE;
      wait_cnt_r <= 4'd0;
    end else begin
      resp_src_r <= resp_src_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Steer returning memory data to the port that was granted last cycle
  always_comb begin
    if_valid = 1'b0;
    if_rdata = {D_WIDTH{1'b0}};
    ls_valid = 1'b0;
    ls_rdata = {D_WIDTH{1'b0}};
    case (resp_src_r)
      RESP_IF: begin
        if_valid = 1'b1;
        if_rdata = mem_rdata;
      end
      RESP_LS_RD: begin
        ls_valid = 1'b1;
        ls_rdata = mem_rdata;
      end
      RESP_LS_WR: begin
        ls_valid = 1'b1;
      end
      default: begin
        if_valid = 1'b0;
        ls_valid = 1'b0;
      end
    endcase
  end

endmodule
